// File: rtl/txt_mem_bus_arb.sv
// Two-master arbiter/sequencer for the text/font memory port.
// Master A (CPU bus glue) and master B (scroll/clear DMA) share one memory
// port. Round-robin grant, one transaction in flight, OK-then-release
// handshake with a cycle timeout in both the BUS and REL phases.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transaction; arbitrate sampled requests on this edge
// BUS   | strobe asserted for sel_q, waiting for busOK=1 or timeout
// REL   | strobes dropped, waiting for busOK=0 (or timeout) before IDLE
module txt_mem_bus_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ack,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [ADDR_W-1:0] busAddr,
    inout  wire  [DATA_W-1:0] busData,
    output logic              busOE,
    output logic              busWR,
    input  logic              busOK
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_REL  = 2'd2
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    state_t            state_q;
    logic              sel_q;      // 0 = A, 1 = B
    logic              last_q;     // last granted master, 0 = A, 1 = B
    logic [TMO_W-1:0]  tmo_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drv_q;      // write data on busData
    logic              oe_q;
    logic              wr_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic              a_ack_q;
    logic              b_ack_q;
    logic              a_err_q;
    logic              b_err_q;

    logic              win_b_d;
    logic              win_we_d;
    logic [ADDR_W-1:0] win_addr_d;
    logic [DATA_W-1:0] win_wdata_d;

    // Round-robin pick: a lone requester wins; on contention the master
    // that was not served last wins.
    always_comb begin
        win_b_d = 1'b0;
        if (a_req && b_req) begin
            win_b_d = ~last_q;
        end else if (b_req) begin
            win_b_d = 1'b1;
        end
        win_we_d    = win_b_d ? b_we    : a_we;
        win_addr_d  = win_b_d ? b_addr  : a_addr;
        win_wdata_d = win_b_d ? b_wdata : a_wdata;
    end

    // Sequencer: grant, strobe until OK or timeout, then wait for OK release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            tmo_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            drv_q     <= 1'b0;
            oe_q      <= 1'b0;
            wr_q      <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            a_err_q <= 1'b0;
            b_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (a_req || b_req) begin
                        sel_q   <= win_b_d;
                        last_q  <= win_b_d;
                        tmo_q   <= '0;
                        addr_q  <= win_addr_d;
                        wdata_q <= win_wdata_d;
                        oe_q    <= ~win_we_d;
                        wr_q    <= win_we_d;
                        drv_q   <= win_we_d;
                        state_q <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (busOK) begin
                        if (!wr_q) begin
                            if (sel_q) b_rdata_q <= busData;
                            else       a_rdata_q <= busData;
                        end
                        if (sel_q) b_ack_q <= 1'b1;
                        else       a_ack_q <= 1'b1;
                        oe_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        drv_q   <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= S_REL;
                    end else if (tmo_q == TMO_LAST) begin
                        if (sel_q) begin
                            b_err_q   <= 1'b1;
                            b_rdata_q <= '1;
                        end else begin
                            a_err_q   <= 1'b1;
                            a_rdata_q <= '1;
                        end
                        oe_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        drv_q   <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= S_REL;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_REL: begin
                    // A memory that never releases OK is abandoned silently.
                    if (!busOK || tmo_q == TMO_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busData = drv_q ? wdata_q : {DATA_W{1'bz}};
    assign busAddr = addr_q;
    assign busOE   = oe_q;
    assign busWR   = wr_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_err   = a_err_q;
    assign b_err   = b_err_q;

endmodule

// File: tb/tb_txt_mem_bus_arb.sv
// Testbench for txt_mem_bus_arb: directed scenarios plus a randomized run
// against a transaction-level round-robin / memory reference model.
module tb_txt_mem_bus_arb;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [31:0] busAddr;
    wire  [31:0] busData;
    logic        busOE, busWR;
    wire         busOK;

    logic        ok_force, ok_val, ok_gate;

    int vectors    = 0;
    int miscompares = 0;

    // Memory read contents: one fixed word, everything else derived from address.
    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        if (addr == 32'h10) return 32'h12345678;
        return addr ^ 32'hA5A5_5A5A;
    endfunction

    assign busOK   = ok_force ? ok_val : ((busOE | busWR) & ok_gate);
    assign busData = busOE ? mem_data(busAddr) : 32'bz;

    always #5 clock = ~clock;

    txt_mem_bus_arb #(.ADDR_W(32), .DATA_W(32), .TMO_W(8), .TMO_MAX(200)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
        .busAddr(busAddr), .busData(busData), .busOE(busOE), .busWR(busWR),
        .busOK(busOK)
    );

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        ok_force = 0; ok_val = 0; ok_gate = 1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        vectors++;
        if ({busOE, busWR, a_ack, b_ack, a_err, b_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b want 000000", {busOE, busWR, a_ack, b_ack, a_err, b_err});
        end
        vectors++;
        if (busAddr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_addr: got %h want 0", busAddr);
        end
        vectors++;
        if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h/%h want 0/0", a_rdata, b_rdata);
        end
        do_reset();
    endtask

    // Single read from A against zero-wait memory.
    task automatic test_read();
        int b_pulses = 0;
        int a_pulses = 0;
        do_reset();
        a_req = 1; a_we = 0; a_addr = 32'h10;
        @(negedge clock);
        vectors++;
        if (busOE !== 1'b1 || busWR !== 1'b0 || busAddr !== 32'h10 || a_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL read_issue: oe=%b wr=%b addr=%h ack=%b want 1 0 00000010 0", busOE, busWR, busAddr, a_ack);
        end
        @(negedge clock);
        vectors++;
        if (a_ack !== 1'b1 || a_rdata !== 32'h12345678 || busOE !== 1'b0) begin
            miscompares++;
            $display("FAIL read_ack: ack=%b rdata=%h oe=%b want 1 12345678 0", a_ack, a_rdata, busOE);
        end
        a_req = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            a_pulses += int'(a_ack);
            b_pulses += int'(b_ack);
        end
        vectors++;
        if (a_pulses != 0 || b_pulses != 0) begin
            miscompares++;
            $display("FAIL read_single_pulse: extra a_ack=%0d b_ack=%0d want 0 0", a_pulses, b_pulses);
        end
    endtask

    // Simultaneous writes from reset: order A, B, A with A re-requesting.
    task automatic test_write_rr();
        int order[3];
        int ngrant = 0;
        int acnt = 0;
        logic prev_s = 0;
        logic [31:0] exp_d;
        do_reset();
        a_req = 1; a_we = 1; a_addr = 32'h100; a_wdata = 32'hAAAA_0001;
        b_req = 1; b_we = 1; b_addr = 32'h200; b_wdata = 32'hBBBB_0002;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clock);
            if ((busOE | busWR) && !prev_s && ngrant < 3) begin
                order[ngrant] = (busAddr == 32'h200) ? 1 : 0;
                exp_d = (busAddr == 32'h200) ? 32'hBBBB_0002 :
                        (busAddr == 32'h104) ? 32'hAAAA_0003 : 32'hAAAA_0001;
                vectors++;
                if (busWR !== 1'b1 || busData !== exp_d) begin
                    miscompares++;
                    $display("FAIL write_data: wr=%b data=%h want 1 %h", busWR, busData, exp_d);
                end
                ngrant++;
            end
            prev_s = busOE | busWR;
            if (a_ack) begin
                acnt++;
                if (acnt == 1) begin
                    a_addr = 32'h104; a_wdata = 32'hAAAA_0003;
                end else begin
                    a_req = 0;
                end
            end
            if (b_ack) b_req = 0;
            if (ngrant == 3 && !a_req && !b_req) break;
        end
        vectors++;
        if (ngrant != 3) begin
            miscompares++;
            $display("FAIL write_grants: got %0d want 3", ngrant);
        end else begin
            vectors++;
            if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
                miscompares++;
                $display("FAIL write_order: got %0d,%0d,%0d want 0,1,0", order[0], order[1], order[2]);
            end
        end
        a_req = 0; b_req = 0;
        repeat (3) @(negedge clock);
    endtask

    // busOK stuck low: abort exactly 200 cycles after grant.
    task automatic test_timeout();
        int cnt = 0;
        int acks = 0;
        do_reset();
        ok_force = 1; ok_val = 0;
        a_req = 1; a_we = 0; a_addr = 32'h20;
        @(negedge clock);
        vectors++;
        if (busOE !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_issue: oe=%b want 1", busOE);
        end
        while (cnt < 260) begin
            @(negedge clock);
            cnt++;
            acks += int'(a_ack);
            if (a_err) break;
            if (busOE !== 1'b1) break;
        end
        vectors++;
        if (cnt != 200 || a_err !== 1'b1 || busOE !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_cycles: cycles=%0d err=%b oe=%b want 200 1 0", cnt, a_err, busOE);
        end
        vectors++;
        if (a_rdata !== 32'hFFFF_FFFF || acks != 0) begin
            miscompares++;
            $display("FAIL tmo_rdata: rdata=%h acks=%0d want ffffffff 0", a_rdata, acks);
        end
        a_req = 0;
        @(negedge clock);
        vectors++;
        if (a_err !== 1'b0 || a_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_pulse: err=%b ack=%b want 0 0", a_err, a_ack);
        end
        ok_force = 0;
        repeat (2) @(negedge clock);
    endtask

    // busOK held after completion keeps the arbiter in release; B waits.
    task automatic test_rel_hold();
        int early = 0;
        do_reset();
        ok_force = 1; ok_val = 0;
        a_req = 1; a_we = 1; a_addr = 32'h280; a_wdata = 32'h1357_9BDF;
        @(negedge clock);
        ok_val = 1;
        @(negedge clock);
        vectors++;
        if (a_ack !== 1'b1 || busWR !== 1'b0) begin
            miscompares++;
            $display("FAIL rel_ack: ack=%b wr=%b want 1 0", a_ack, busWR);
        end
        a_req = 0;
        b_req = 1; b_we = 0; b_addr = 32'h300;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (busOE | busWR) early++;
        end
        ok_force = 0;
        ok_val = 0;
        @(negedge clock);
        if (busOE | busWR) early++;
        vectors++;
        if (early != 0) begin
            miscompares++;
            $display("FAIL rel_hold: grant cycles during hold=%0d want 0", early);
        end
        @(negedge clock);
        vectors++;
        if (busOE !== 1'b1 || busAddr !== 32'h300) begin
            miscompares++;
            $display("FAIL rel_grant_b: oe=%b addr=%h want 1 00000300", busOE, busAddr);
        end
        @(negedge clock);
        vectors++;
        if (b_ack !== 1'b1 || b_rdata !== mem_data(32'h300)) begin
            miscompares++;
            $display("FAIL rel_b_read: ack=%b rdata=%h want 1 %h", b_ack, b_rdata, mem_data(32'h300));
        end
        b_req = 0;
        repeat (2) @(negedge clock);
    endtask

    // Asynchronous reset during a stalled write.
    task automatic test_reset_abort();
        int waitc = 0;
        do_reset();
        ok_force = 1; ok_val = 0;
        b_req = 1; b_we = 1; b_addr = 32'h400; b_wdata = 32'hCAFE_0001;
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if (busWR !== 1'b1 || busData !== 32'hCAFE_0001) begin
            miscompares++;
            $display("FAIL abort_pre: wr=%b data=%h want 1 cafe0001", busWR, busData);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({busWR, busOE, a_ack, b_ack, a_err, b_err} !== 6'b0) begin
            miscompares++;
            $display("FAIL abort_async: wr,oe,acks,errs=%b want 000000", {busWR, busOE, a_ack, b_ack, a_err, b_err});
        end
        @(negedge clock);
        reset = 1'b1;
        ok_force = 0;
        a_req = 1; a_we = 0; a_addr = 32'h500;
        b_addr = 32'h600; b_wdata = 32'hCAFE_0002;
        @(negedge clock);
        vectors++;
        if (busOE !== 1'b1 || busAddr !== 32'h500) begin
            miscompares++;
            $display("FAIL abort_next_grant: oe=%b addr=%h want 1 00000500", busOE, busAddr);
        end
        @(negedge clock);
        vectors++;
        if (a_ack !== 1'b1 || a_rdata !== mem_data(32'h500)) begin
            miscompares++;
            $display("FAIL abort_a_read: ack=%b rdata=%h want 1 %h", a_ack, a_rdata, mem_data(32'h500));
        end
        a_req = 0;
        while (!b_ack && waitc < 20) begin
            @(negedge clock);
            waitc++;
        end
        vectors++;
        if (b_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_b_done: b_ack=%b want 1", b_ack);
        end
        b_req = 0;
        repeat (2) @(negedge clock);
    endtask

    // A held continuously: acks every 3 cycles against zero-wait memory.
    task automatic test_back_to_back();
        int ack_at[5];
        int nack = 0;
        do_reset();
        a_req = 1; a_we = 0; a_addr = 32'h700;
        for (int cyc = 1; cyc <= 40 && nack < 5; cyc++) begin
            @(negedge clock);
            if (a_ack) begin
                ack_at[nack] = cyc;
                nack++;
                vectors++;
                if (a_rdata !== mem_data(32'h700)) begin
                    miscompares++;
                    $display("FAIL b2b_rdata: got %h want %h", a_rdata, mem_data(32'h700));
                end
            end
        end
        a_req = 0;
        vectors++;
        if (nack != 5) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d acks want 5", nack);
        end else begin
            vectors++;
            if (ack_at[0] != 2) begin
                miscompares++;
                $display("FAIL b2b_latency: first ack cycle %0d want 2", ack_at[0]);
            end
            for (int i = 1; i < 5; i++) begin
                vectors++;
                if (ack_at[i] - ack_at[i-1] != 3) begin
                    miscompares++;
                    $display("FAIL b2b_spacing: ack %0d spacing %0d want 3", i, ack_at[i] - ack_at[i-1]);
                end
            end
        end
        repeat (3) @(negedge clock);
    endtask

    // Randomized traffic with random wait states against a transaction model.
    task automatic test_random();
        int owner = -1;
        int wait_n = 0;
        int issued = 0;
        int done = 0;
        logic last_is_b = 1'b1;
        logic pa = 0, pb = 0, prev_s = 0, strobe;
        logic win_b, a_done, b_done;
        logic [31:0] e_addr, e_wdata;
        logic e_we;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            strobe = busOE | busWR;
            if (strobe && !prev_s) begin
                vectors++;
                if (!pa && !pb) begin
                    miscompares++;
                    $display("FAIL rnd_spurious: grant with no request addr=%h", busAddr);
                end else begin
                    if (pa && pb) win_b = !last_is_b;
                    else          win_b = pb;
                    e_addr  = win_b ? b_addr  : a_addr;
                    e_we    = win_b ? b_we    : a_we;
                    e_wdata = win_b ? b_wdata : a_wdata;
                    vectors++;
                    if (busAddr !== e_addr || busWR !== e_we || busOE !== !e_we) begin
                        miscompares++;
                        $display("FAIL rnd_grant: addr=%h wr=%b oe=%b want %h %b %b", busAddr, busWR, busOE, e_addr, e_we, !e_we);
                    end
                    if (e_we) begin
                        vectors++;
                        if (busData !== e_wdata) begin
                            miscompares++;
                            $display("FAIL rnd_wdata: got %h want %h", busData, e_wdata);
                        end
                    end
                    owner = win_b ? 1 : 0;
                    last_is_b = win_b;
                    issued++;
                end
                wait_n = $urandom_range(0, 3);
                ok_gate = (wait_n == 0);
            end else if (strobe) begin
                if (wait_n > 0) wait_n--;
                ok_gate = (wait_n == 0);
            end
            prev_s = strobe;
            a_done = 0;
            b_done = 0;
            if (a_ack || a_err) begin
                vectors++;
                if (owner != 0 || a_err) begin
                    miscompares++;
                    $display("FAIL rnd_a_done: ack=%b err=%b owner=%0d want ack from owner 0", a_ack, a_err, owner);
                end else if (!a_we) begin
                    vectors++;
                    if (a_rdata !== mem_data(a_addr)) begin
                        miscompares++;
                        $display("FAIL rnd_a_rdata: got %h want %h", a_rdata, mem_data(a_addr));
                    end
                end
                owner = -1;
                a_done = 1;
                done++;
            end
            if (b_ack || b_err) begin
                vectors++;
                if (owner != 1 || b_err) begin
                    miscompares++;
                    $display("FAIL rnd_b_done: ack=%b err=%b owner=%0d want ack from owner 1", b_ack, b_err, owner);
                end else if (!b_we) begin
                    vectors++;
                    if (b_rdata !== mem_data(b_addr)) begin
                        miscompares++;
                        $display("FAIL rnd_b_rdata: got %h want %h", b_rdata, mem_data(b_addr));
                    end
                end
                owner = -1;
                b_done = 1;
                done++;
            end
            if (a_done) a_req = 0;
            if (b_done) b_req = 0;
            if (cyc < 2950) begin
                if (!a_req && (a_done ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0))) begin
                    a_req = 1; a_we = $urandom_range(0, 1) == 1;
                    a_addr = {1'b0, 31'($urandom)}; a_wdata = $urandom;
                end
                if (!b_req && (b_done ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0))) begin
                    b_req = 1; b_we = $urandom_range(0, 1) == 1;
                    b_addr = {1'b1, 31'($urandom)}; b_wdata = $urandom;
                end
            end
            pa = a_req;
            pb = b_req;
        end
        vectors++;
        if (issued != done || a_req || b_req || issued < 100) begin
            miscompares++;
            $display("FAIL rnd_drain: issued=%0d done=%0d a_req=%b b_req=%b", issued, done, a_req, b_req);
        end
        ok_gate = 1;
    endtask

    initial begin
        reset = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        ok_force = 0; ok_val = 0; ok_gate = 1;
        test_reset();
        test_read();
        test_write_rr();
        test_timeout();
        test_rel_hold();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
